// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding imem request,
// one-entry fetch buffer and IF/ID register.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   StallD, FlushD        hazard unit hold / invalidate of IF/ID
//   PCSrcE, PCTargetE     redirect from execute
//   ImemReq, ImemAddr     request valid and address (= PCF)
//   ImemGnt               request accepted this cycle
//   ImemRValid, ImemRData response valid and instruction
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register outputs
// Optional (FETCH_PERF_CNT_EN):
//   FetchCount, FetchStallCount  accepted fetches / stalled cycles
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FetchStallCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] pend_pc;
  logic        kill;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        gnt;
  logic        rsp_ok;
  logic        id_free;
  logic        drain;
  logic        buf_wr;
  logic [31:0] pc_tgt;

  assign pc_tgt   = PCTargetE & 32'hFFFF_FFFC;
  assign ImemReq  = (state == S_REQ) && !buf_valid;
  assign ImemAddr = pcf;
  assign gnt      = ImemReq && ImemGnt;
  // a response is kept only if no kill is pending and no redirect now
  assign rsp_ok   = (state == S_WAIT) && ImemRValid
                    && !kill && !PCSrcE;
  assign id_free  = !ValidD || !StallD;
  assign drain    = buf_valid && id_free && !FlushD && !PCSrcE;
  // buffer takes the response whenever it cannot go straight to ID
  assign buf_wr   = rsp_ok && (drain || FlushD || !id_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pcf       <= RESET_PC;
      pend_pc   <= 32'd0;
      kill      <= 1'b0;
      buf_valid <= 1'b0;
      buf_instr <= 32'd0;
      buf_pc    <= 32'd0;
      ValidD    <= 1'b0;
      InstrD    <= NOP_INSTR;
      PCD       <= 32'd0;
      PCPlus4D  <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (gnt) begin
            state   <= S_WAIT;
            pend_pc <= pcf;
            // grant alongside redirect: request is in flight but dead
            kill    <= PCSrcE;
          end
        end
        S_WAIT: begin
          if (ImemRValid) begin
            state <= S_REQ;
            kill  <= 1'b0;
          end else if (PCSrcE) begin
            kill  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (PCSrcE)
        pcf <= pc_tgt;
      else if (gnt)
        pcf <= pcf + 32'd4;

      if (PCSrcE)
        buf_valid <= 1'b0;
      else if (buf_wr)
        buf_valid <= 1'b1;
      else if (drain)
        buf_valid <= 1'b0;

      if (buf_wr) begin
        buf_instr <= ImemRData;
        buf_pc    <= pend_pc;
      end

      if (FlushD) begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end else if (drain) begin
        ValidD   <= 1'b1;
        InstrD   <= buf_instr;
        PCD      <= buf_pc;
        PCPlus4D <= buf_pc + 32'd4;
      end else if (id_free) begin
        if (rsp_ok) begin
          ValidD   <= 1'b1;
          InstrD   <= ImemRData;
          PCD      <= pend_pc;
          PCPlus4D <= pend_pc + 32'd4;
        end else begin
          ValidD <= 1'b0;
          InstrD <= NOP_INSTR;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount      <= 32'd0;
      FetchStallCount <= 32'd0;
    end else begin
      if (rsp_ok)
        FetchCount <= FetchCount + 32'd1;
      if ((ImemReq && !ImemGnt) || (buf_valid && StallD))
        FetchStallCount <= FetchStallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a
// one-cycle-latency instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] FetchStallCount;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;

  logic        gnt_en;
  logic        rv_en;
  logic        pend;
  logic [31:0] pdata;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRValid (ImemRValid),
    .ImemRData  (ImemRData),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount      (FetchCount),
    .FetchStallCount (FetchStallCount)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h0050_0093 + {a[21:0], 10'b0};
  endfunction

  // one clock: drive memory for this cycle, advance to next negedge
  task automatic cyc();
    logic [31:0] a;
    logic        g;
    logic        r;
    ImemGnt    = ImemReq && gnt_en;
    ImemRValid = pend && rv_en;
    ImemRData  = ImemRValid ? pdata : 32'hDEAD_BEEF;
    a = ImemAddr;
    g = ImemGnt;
    r = ImemRValid;
    @(posedge clk);
    #1;
    if (r) pend = 1'b0;
    if (g) begin
      pend  = 1'b1;
      pdata = imem(a);
    end
    ImemGnt    = 1'b0;
    ImemRValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      if (ValidD === 1'b1) begin
        to = 1'b0;
        break;
      end
      cyc();
    end
    if (ValidD === 1'b1) to = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'd0;
    ImemGnt    = 1'b0;
    ImemRValid = 1'b0;
    ImemRData  = 32'd0;
    gnt_en     = 1'b1;
    rv_en      = 1'b1;
    pend       = 1'b0;
    pdata      = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ValidD, InstrD} !== {1'b0, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL rst_id: got %b %h want 0 00000013",
               ValidD, InstrD);
    end
    n_cmp++;
    if ({PCD, PCPlus4D} !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_pc: got %h %h want 0 0", PCD, PCPlus4D);
    end
    n_cmp++;
    if ({ImemReq, ImemAddr} !== {1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL rst_req: got %b %h want 0 0",
               ImemReq, ImemAddr);
    end
    rst_n = 1'b1;
    n_cmp++;
    if (ImemReq !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_req: got %b want 0", ImemReq);
    end
    cyc();
    n_cmp++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL first_req: got %b %h want 1 0",
               ImemReq, ImemAddr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    do_reset();
    cyc();
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      n_cmp++;
      if ({ImemReq, ImemAddr} !== {1'b1, a}) begin
        n_bad++;
        $display("FAIL basic_req%0d: got %b %h want 1 %h",
                 k, ImemReq, ImemAddr, a);
      end
      cyc();
      n_cmp++;
      if ({ImemReq, ValidD} !== 2'b00) begin
        n_bad++;
        $display("FAIL basic_wait%0d: got req %b vld %b want 0 0",
                 k, ImemReq, ValidD);
      end
      cyc();
      n_cmp++;
      if ({ValidD, InstrD, PCD, PCPlus4D} !==
          {1'b1, imem(a), a, a + 32'd4}) begin
        n_bad++;
        $display("FAIL basic_id%0d: got %b %h %h %h want 1 %h %h %h",
                 k, ValidD, InstrD, PCD, PCPlus4D,
                 imem(a), a, a + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) cyc();
    StallD = 1'b1;
    cyc();
    n_cmp++;
    if ({ImemReq, ValidD, InstrD} !== {2'b01, imem(0)}) begin
      n_bad++;
      $display("FAIL stall_hold0: got %b %b %h want 0 1 %h",
               ImemReq, ValidD, InstrD, imem(0));
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if ({ImemReq, ValidD, InstrD, PCD} !==
          {2'b01, imem(0), 32'd0}) begin
        n_bad++;
        $display("FAIL stall_full%0d: got %b %b %h %h want 0 1 %h 0",
                 i, ImemReq, ValidD, InstrD, PCD, imem(0));
      end
    end
    StallD = 1'b0;
    cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !==
        {1'b1, imem(4), 32'd4, 32'd8}) begin
      n_bad++;
      $display("FAIL stall_drain: got %b %h %h %h want 1 %h 4 8",
               ValidD, InstrD, PCD, PCPlus4D, imem(4));
    end
    n_cmp++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'd8}) begin
      n_bad++;
      $display("FAIL stall_req: got %b %h want 1 8",
               ImemReq, ImemAddr);
    end
    cyc();
    n_cmp++;
    if (ValidD !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_nodup: got vld %b want 0", ValidD);
    end
    cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD} !== {1'b1, imem(8), 32'd8}) begin
      n_bad++;
      $display("FAIL stall_next: got %b %h %h want 1 %h 8",
               ValidD, InstrD, PCD, imem(8));
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    repeat (2) cyc();
    rv_en     = 1'b0;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0102;
    cyc();
    PCSrcE = 1'b0;
    rv_en  = 1'b1;
    n_cmp++;
    if ({ImemReq, ValidD} !== 2'b00) begin
      n_bad++;
      $display("FAIL rdw_wait: got req %b vld %b want 0 0",
               ImemReq, ValidD);
    end
    cyc();
    n_cmp++;
    if ({ValidD, ImemReq, ImemAddr} !== {2'b01, 32'h100}) begin
      n_bad++;
      $display("FAIL rdw_req: got vld %b req %b %h want 0 1 100",
               ValidD, ImemReq, ImemAddr);
    end
    cyc();
    n_cmp++;
    if (ValidD !== 1'b0) begin
      n_bad++;
      $display("FAIL rdw_bubble: got vld %b want 0", ValidD);
    end
    cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !==
        {1'b1, imem(32'h100), 32'h100, 32'h104}) begin
      n_bad++;
      $display("FAIL rdw_id: got %b %h %h %h want 1 %h 100 104",
               ValidD, InstrD, PCD, PCPlus4D, imem(32'h100));
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    cyc();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0200;
    cyc();
    PCSrcE = 1'b0;
    n_cmp++;
    if (ImemReq !== 1'b0) begin
      n_bad++;
      $display("FAIL rdg_drop: got req %b want 0", ImemReq);
    end
    cyc();
    n_cmp++;
    if ({ValidD, ImemReq, ImemAddr} !== {2'b01, 32'h200}) begin
      n_bad++;
      $display("FAIL rdg_req: got vld %b req %b %h want 0 1 200",
               ValidD, ImemReq, ImemAddr);
    end
    repeat (2) cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD} !== {1'b1, imem(32'h200), 32'h200}) begin
      n_bad++;
      $display("FAIL rdg_id: got %b %h %h want 1 %h 200",
               ValidD, InstrD, PCD, imem(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFE;
    cyc();
    PCSrcE = 1'b0;
    n_cmp++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_bad++;
      $display("FAIL wrap_req: got %b %h want 1 fffffffc",
               ImemReq, ImemAddr);
    end
    repeat (2) cyc();
    n_cmp++;
    if ({ValidD, PCD, PCPlus4D, ImemAddr} !==
        {1'b1, 32'hFFFF_FFFC, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL wrap_id: got %b %h %h %h want 1 fffffffc 0 0",
               ValidD, PCD, PCPlus4D, ImemAddr);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    repeat (3) cyc();
    StallD = 1'b1;
    FlushD = 1'b1;
    cyc();
    n_cmp++;
    if ({ValidD, InstrD} !== {1'b0, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL flush: got %b %h want 0 00000013",
               ValidD, InstrD);
    end
    StallD = 1'b0;
    FlushD = 1'b0;
    cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD} !== {1'b1, imem(4), 32'd4}) begin
      n_bad++;
      $display("FAIL flush_next: got %b %h %h want 1 %h 4",
               ValidD, InstrD, PCD, imem(4));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) cyc();
    StallD = 1'b1;
    rv_en  = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ValidD, InstrD, PCD, PCPlus4D, ImemReq} !==
        {1'b0, 32'h0000_0013, 64'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid: got %b %h %h %h %b want 0 13 0 0 0",
               ValidD, InstrD, PCD, PCPlus4D, ImemReq);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    StallD = 1'b0;
    rv_en  = 1'b1;
    cyc();
    n_cmp++;
    if ({ValidD, ImemReq, ImemAddr} !== {2'b01, 32'd0}) begin
      n_bad++;
      $display("FAIL rstmid_req: got vld %b req %b %h want 0 1 0",
               ValidD, ImemReq, ImemAddr);
    end
    repeat (2) cyc();
    n_cmp++;
    if ({ValidD, InstrD, PCD} !== {1'b1, imem(0), 32'd0}) begin
      n_bad++;
      $display("FAIL rstmid_id: got %b %h %h want 1 %h 0",
               ValidD, InstrD, PCD, imem(0));
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    bit to;
    do_reset();
    cyc();
    gnt_en = 1'b0;
    repeat (2) cyc();
    gnt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      wait_valid(8, to);
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL perf_timeout%0d: got no ValidD want ValidD=1", i);
      end
    end
    n_cmp++;
    if ({FetchCount, FetchStallCount} !== {32'd5, 32'd2}) begin
      n_bad++;
      $display("FAIL perf_cnt: got %0d %0d want 5 2",
               FetchCount, FetchStallCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_flush_stall();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the decode stage through the IF/ID pipeline register. Produces InstrD, PCD, PCPlus4D and ValidD.
- Owns PCF and the request/response handshake to instruction memory, with a single outstanding request.
- Uses a one-entry fetch buffer so responses survive decode stalls.
- Accepts redirects from execute (PCSrcE/PCTargetE) and stall/flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented while ValidD=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- StallD  in  1  hold IF/ID register contents
- FlushD  in  1  invalidate IF/ID register
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  32  redirect target
- ImemReq  out  1  fetch request valid
- ImemAddr  out  32  fetch address (= PCF)
- ImemGnt  in  1  memory accepted request this cycle
- ImemRValid  in  1  response valid
- ImemRData  in  32  response instruction
- InstrD  out  32  instruction to decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD+4
- ValidD  out  1  InstrD is a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=IDLE, buffer empty, kill=0.
  - ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ImemReq=0.
- PC and addresses:
  - ImemAddr=PCF; PCF[1:0] always 2'b00.
  - Redirect targets have bits [1:0] forced to 0.
  - PC+4 wraps modulo 2^32.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: ImemReq=1 only if the buffer is empty. On ImemGnt: latch PCF as pending PC, PCF<=PCF+4, go to WAIT.
  - WAIT: ImemReq=0. On ImemRValid, go to REQ.
- Response handling (ImemRValid in WAIT, kill=0):
  - ID register free (ValidD=0 or StallD=0): load InstrD=ImemRData, PCD=pending PC, PCPlus4D=pending+4, ValidD=1.
  - Otherwise: write the response into the buffer.
- Buffer drain:
  - When StallD=0 and the buffer is full, the buffer loads the ID register first.
  - A response arriving in the same cycle goes into the buffer, so the buffer never overflows.
  - If the buffer is full and the ID register is stalled, ImemReq is held at 0.
- Redirect (PCSrcE=1), highest priority:
  - PCF<=PCTargetE and the buffer is cleared.
  - In WAIT without ImemRValid: set kill=1. The next response is discarded, kill clears, state goes to REQ.
  - In WAIT with ImemRValid in the same cycle: the response is discarded.
  - In REQ with ImemGnt in the same cycle: the grant is ignored, ImemReq drops next cycle, and the same-cycle-accepted request is treated as killed.
- FlushD:
  - Next cycle ValidD=0 and InstrD=NOP_INSTR; PCD/PCPlus4D are don't-care.
  - FlushD overrides StallD.
  - Flush does not clear the buffer unless PCSrcE is also set.
- StallD=1, FlushD=0: InstrD/PCD/PCPlus4D/ValidD hold their values.
- Latency: ImemGnt to ValidD=1 is 1 cycle after ImemRValid when not stalled.
- Reset mid-operation: all state is abandoned immediately; any in-flight response after rst_n rises while in IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs FetchCount (32) and FetchStallCount (32), both reset to 0.
  - FetchCount increments on each non-killed response accepted.
  - FetchStallCount increments each cycle ImemReq=1 && ImemGnt=0, or the buffer is full with StallD=1.
  - Both counters wrap at 2^32.
- Without the macro: the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Reset release, memory grants immediately, responds next cycle with 32'h00500093 -> ImemAddr 0,4,8…; ValidD=1, InstrD=00500093, PCD=0, PCPlus4D=4.
- StallD=1 for 3 cycles while two responses arrive -> first held in ID, second in buffer, ImemReq=0 while buffer full; after release, order preserved, no loss or duplicate.
- PCSrcE=1, PCTargetE=32'h0000_0102 while in WAIT -> next ImemAddr=32'h100 after the killed response is discarded; the discarded data never reaches ValidD.
- FlushD and StallD both 1 -> ValidD=0, InstrD=32'h00000013.
- rst_n pulsed low in WAIT -> outputs immediately at reset values; first fetch after release is RESET_PC.
- FETCH_PERF_CNT_EN: 5 fetches with 2 cycles of ImemGnt=0 -> FetchCount=5, FetchStallCount=2.
